conware_gen_ctrl: RTL and testbench

CONWARE_GEN_CTRL -- requirements
Module: conware_gen_ctrl

---
 rtl/conware_gen_ctrl.sv | 106 ++++++++++
 tb/tb_conware_gen_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conware_gen_ctrl.sv
// Generation sequencer for a streaming cell-update core: gates the core's input and
// output handshakes per frame, counts generations and marks the last beat of each frame.
module conware_gen_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_rows,
    input  logic [CNT_W-1:0] cfg_gens,
    input  logic             in_beat,
    input  logic             out_beat,
    output logic             in_en,
    output logic             out_en,
    output logic             frame_last,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] gen_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | input and output beats of the current generation enabled
    // DRAIN  | all input beats taken, waiting for the remaining output beats
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [31:0]      total;
    logic [31:0]      in_cnt;
    logic [31:0]      out_cnt;
    logic [CNT_W-1:0] gens_cfg;

    logic [31:0]      in_cnt_nxt;
    logic [31:0]      out_cnt_nxt;
    logic [CNT_W-1:0] gen_nxt;

    // Outputs are decoded from registered state/counters only, so reset clears them at once.
    assign in_en      = (state == STREAM) && (in_cnt < total);
    assign out_en     = ((state == STREAM) || (state == DRAIN)) && (out_cnt < total);
    assign frame_last = out_en && (out_cnt == total - 32'd1);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    assign in_cnt_nxt  = in_cnt + {31'd0, (in_beat && in_en)};
    assign out_cnt_nxt = out_cnt + {31'd0, (out_beat && out_en)};
    assign gen_nxt     = gen_count + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            total     <= 32'd0;
            in_cnt    <= 32'd0;
            out_cnt   <= 32'd0;
            gens_cfg  <= '0;
            gen_count <= '0;
            aborted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        total     <= 32'(cfg_rows) * 32'(WIDTH);
                        gens_cfg  <= cfg_gens;
                        in_cnt    <= 32'd0;
                        out_cnt   <= 32'd0;
                        gen_count <= '0;
                        aborted   <= 1'b0;
                        if ((cfg_rows == '0) || (cfg_gens == '0))
                            state <= DONE;
                        else
                            state <= STREAM;
                    end
                end
                STREAM, DRAIN: begin
                    if (abort) begin
                        state   <= IDLE;
                        in_cnt  <= 32'd0;
                        out_cnt <= 32'd0;
                        aborted <= 1'b1;
                    end else if (out_cnt_nxt == total) begin
                        // Frame fully emitted: close this generation and maybe start the next.
                        gen_count <= gen_nxt;
                        in_cnt    <= 32'd0;
                        out_cnt   <= 32'd0;
                        state     <= (gen_nxt < gens_cfg) ? STREAM : DONE;
                    end else begin
                        in_cnt  <= in_cnt_nxt;
                        out_cnt <= out_cnt_nxt;
                        if (in_cnt_nxt == total)
                            state <= DRAIN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conware_gen_ctrl.sv
// Directed-vector bench for conware_gen_ctrl; expected counts are hand-computed
// from WIDTH=8 and the configured rows/generations.
module tb_conware_gen_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             ACLK;
    logic             ARESET;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_rows;
    logic [CNT_W-1:0] cfg_gens;
    logic             in_beat;
    logic             out_beat;
    logic             in_en;
    logic             out_en;
    logic             frame_last;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] gen_count;

    conware_gen_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .cfg_rows(cfg_rows), .cfg_gens(cfg_gens),
        .in_beat(in_beat), .out_beat(out_beat),
        .in_en(in_en), .out_en(out_en), .frame_last(frame_last),
        .busy(busy), .done(done), .aborted(aborted), .gen_count(gen_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    // stimulus controls applied at each falling edge
    logic in_drv, out_drv, stall, st_drv, ab_drv;

    // per-job accumulators
    int acc_in, acc_out, acc_fl, acc_done, acc_busy, acc_drain;
    int acc_inen, acc_outen, fl_idx, cyc_n, last_out_cyc, done_cyc;
    logic drain_prev;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        acc_in = 0; acc_out = 0; acc_fl = 0; acc_done = 0; acc_busy = 0;
        acc_drain = 0; acc_inen = 0; acc_outen = 0; fl_idx = 0; cyc_n = 0;
        last_out_cyc = -1; done_cyc = -1; drain_prev = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, observe 1 ns later, before the rising edge.
    task automatic cyc();
        logic drain_now;
        @(negedge ACLK);
        start    = st_drv;
        abort    = ab_drv;
        in_beat  = in_drv;
        out_beat = stall ? !in_en : out_drv;
        #1;
        cyc_n++;
        if (busy) acc_busy++;
        if (done) begin acc_done++; done_cyc = cyc_n; end
        if (in_en) acc_inen++;
        if (out_en) acc_outen++;
        if (in_beat && in_en) acc_in++;
        if (out_beat && out_en) begin acc_out++; last_out_cyc = cyc_n; end
        if (frame_last && out_beat) begin acc_fl++; fl_idx = acc_out; end
        drain_now = busy && !in_en && out_en;
        if (drain_now && !drain_prev) acc_drain++;
        drain_prev = drain_now;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic launch(input int rows, input int gens);
        cfg_rows = CNT_W'(rows);
        cfg_gens = CNT_W'(gens);
        st_drv = 1'b1;
        cyc();
        st_drv = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; start = 1'b0; abort = 1'b0; in_beat = 1'b0; out_beat = 1'b0;
        cfg_rows = '0; cfg_gens = '0;
        in_drv = 1'b0; out_drv = 1'b0; stall = 1'b0; st_drv = 1'b0; ab_drv = 1'b0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", {in_en, out_en, frame_last, done, aborted}, 0);
        chk("rst_gen", gen_count, 0);
        ARESET = 1'b0;

        // 1 row, 1 generation, beats every cycle
        clear_acc(); in_drv = 1; out_drv = 1; stall = 0;
        launch(1, 1);
        run(20);
        chk("t1_in", acc_in, 8);
        chk("t1_out", acc_out, 8);
        chk("t1_fl", acc_fl, 1);
        chk("t1_fl_idx", fl_idx, 8);
        chk("t1_done", acc_done, 1);
        chk("t1_done_lat", done_cyc - last_out_cyc, 1);
        chk("t1_busy", acc_busy, 9);
        chk("t1_gen", gen_count, 1);
        chk("t1_drain", acc_drain, 0);

        // 2 rows, 3 generations, output stalled until input completes
        clear_acc(); in_drv = 1; stall = 1;
        launch(2, 3);
        run(120);
        chk("t2_in", acc_in, 48);
        chk("t2_out", acc_out, 48);
        chk("t2_drain", acc_drain, 3);
        chk("t2_fl", acc_fl, 3);
        chk("t2_done", acc_done, 1);
        chk("t2_busy", acc_busy, 97);
        chk("t2_gen", gen_count, 3);

        // zero generations / zero rows go straight to DONE
        clear_acc(); stall = 0; out_drv = 1;
        launch(4, 0);
        run(5);
        chk("t3_busy", acc_busy, 1);
        chk("t3_done", acc_done, 1);
        chk("t3_en", acc_inen + acc_outen, 0);
        chk("t3_gen", gen_count, 0);
        clear_acc();
        launch(0, 5);
        run(5);
        chk("t3b_busy", acc_busy, 1);
        chk("t3b_en", acc_inen + acc_outen, 0);

        // abort during generation 2 of 4
        clear_acc();
        launch(1, 4);
        run(12);
        ab_drv = 1; cyc(); ab_drv = 0;
        clear_acc();
        cyc();
        chk("t4_busy", busy, 0);
        chk("t4_aborted", aborted, 1);
        chk("t4_gen", gen_count, 1);
        chk("t4_in_en", in_en, 0);
        run(20);
        chk("t4_no_done", acc_done, 0);
        clear_acc();
        launch(1, 1);
        cyc();
        chk("t4_clr_aborted", aborted, 0);
        run(15);
        ab_drv = 1; cyc(); cyc(); ab_drv = 0;
        chk("t4_idle_abort", aborted, 0);
        chk("t4_idle_busy", busy, 0);

        // start while busy and in beats after total are ignored
        clear_acc(); in_drv = 1; stall = 1;
        launch(1, 1);
        run(3);
        st_drv = 1; cyc(); st_drv = 0;
        run(6);
        st_drv = 1; cyc(); st_drv = 0;
        run(20);
        chk("t5_in", acc_in, 8);
        chk("t5_out", acc_out, 8);
        chk("t5_busy", acc_busy, 17);
        chk("t5_done", acc_done, 1);
        chk("t5_gen", gen_count, 1);

        // asynchronous reset mid-STREAM with a generation already completed
        clear_acc(); stall = 0; out_drv = 1;
        launch(1, 3);
        run(11);
        chk("t6_pre_gen", gen_count, 1);
        @(negedge ACLK);
        #2 ARESET = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_en", {in_en, out_en, frame_last, done, aborted}, 0);
        chk("t6_gen", gen_count, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        clear_acc();
        run(4);
        chk("t6_idle", acc_busy, 0);

        // recovery job after reset
        clear_acc();
        launch(1, 2);
        run(30);
        chk("t7_out", acc_out, 16);
        chk("t7_fl", acc_fl, 2);
        chk("t7_gen", gen_count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
